// File: rtl/bist_engine_param.sv
// Parametrised BIST engine: functional/test input mux, pattern LFSR,
// scan shift/capture sequencing, MISR compaction and golden-signature compare.
module bist_engine_param #(
  parameter int                N_IN       = 3,
  parameter int                N_OUT      = 2,
  parameter int                LFSR_W     = 8,
  parameter logic [LFSR_W-1:0] LFSR_TAPS  = 8'hB8,
  parameter logic [LFSR_W-1:0] LFSR_SEED  = 8'h01,
  parameter int                MISR_W     = 8,
  parameter logic [MISR_W-1:0] MISR_TAPS  = 8'hB8,
  parameter int                SCAN_LEN   = 4,
  parameter int                N_PATTERNS = 100,
  parameter logic [MISR_W-1:0] GOLDEN     = 8'h00
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              bist_start,
  input  logic [N_IN-1:0]   func_in,
  output logic [N_IN-1:0]   dut_in,
  input  logic [N_OUT-1:0]  dut_out,
  output logic              scan_en,
  output logic              scan_in,
  input  logic              scan_out,
  output logic              bist_running,
  output logic              bist_end,
  output logic              pass_fail,
  output logic [MISR_W-1:0] signature
);

  localparam int SW = $clog2(SCAN_LEN + 1);
  localparam int PW = $clog2(N_PATTERNS + 1);
  localparam logic [SW-1:0] SH_LAST  = SW'(SCAN_LEN - 1);
  localparam logic [PW-1:0] PAT_LAST = PW'(N_PATTERNS - 1);

  typedef enum logic [2:0] {
    IDLE, INIT, SHIFT, CAPTURE, UNLOAD, COMPARE, DONE
  } state_t;

  state_t              state_reg, state_next;
  logic [LFSR_W-1:0]   lfsr_reg, lfsr_shifted, lfsr_next;
  logic [MISR_W-1:0]   misr_reg, misr_next, misr_in;
  logic [SW-1:0]       sh_cnt_reg;
  logic [PW-1:0]       pat_cnt_reg;
  logic                pass_fail_reg;
  logic [N_OUT:0]      resp;
  logic                sh_last, pat_last;

  assign sh_last  = (sh_cnt_reg == SH_LAST);
  assign pat_last = (pat_cnt_reg == PAT_LAST);

  // Response word: scan_out in bit 0, functional outputs above, zero-extended.
  assign resp = {dut_out, scan_out};
  for (genvar gi = 0; gi < MISR_W; gi++) begin : g_misr_in
    if (gi <= N_OUT) begin : g_bit
      assign misr_in[gi] = resp[gi];
    end else begin : g_zero
      assign misr_in[gi] = 1'b0;
    end
  end

  // Galois LFSR step and MISR step; an all-zero LFSR would lock up, so reseed.
  always_comb begin
    lfsr_shifted = {1'b0, lfsr_reg[LFSR_W-1:1]} ^ (lfsr_reg[0] ? LFSR_TAPS : '0);
    lfsr_next    = (lfsr_shifted == '0) ? LFSR_SEED : lfsr_shifted;
    misr_next    = {misr_reg[MISR_W-2:0], 1'b0} ^ (misr_reg[MISR_W-1] ? MISR_TAPS : '0) ^ misr_in;
  end

  // Next-state logic and Moore outputs.
  always_comb begin
    state_next   = state_reg;
    dut_in       = lfsr_reg[N_IN-1:0];
    scan_en      = 1'b0;
    scan_in      = 1'b0;
    bist_running = 1'b0;
    bist_end     = 1'b0;
    case (state_reg)
      IDLE: begin
        dut_in = func_in;
        if (bist_start) state_next = INIT;
      end
      INIT: begin
        bist_running = 1'b1;
        state_next   = SHIFT;
      end
      SHIFT: begin
        bist_running = 1'b1;
        scan_en      = 1'b1;
        scan_in      = lfsr_reg[0];
        if (sh_last) state_next = CAPTURE;
      end
      CAPTURE: begin
        bist_running = 1'b1;
        state_next   = pat_last ? UNLOAD : SHIFT;
      end
      UNLOAD: begin
        bist_running = 1'b1;
        scan_en      = 1'b1;
        if (sh_last) state_next = COMPARE;
      end
      COMPARE: begin
        bist_running = 1'b1;
        state_next   = DONE;
      end
      DONE: begin
        bist_end = 1'b1;
        if (bist_start) state_next = INIT;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, pattern/shift counters, LFSR, MISR and verdict registers.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_reg     <= IDLE;
      lfsr_reg      <= LFSR_SEED;
      misr_reg      <= '0;
      sh_cnt_reg    <= '0;
      pat_cnt_reg   <= '0;
      pass_fail_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_next == INIT) begin
        // Entering INIT (from IDLE or DONE): fresh run, old verdict dropped.
        lfsr_reg      <= LFSR_SEED;
        misr_reg      <= '0;
        sh_cnt_reg    <= '0;
        pat_cnt_reg   <= '0;
        pass_fail_reg <= 1'b0;
      end else begin
        case (state_reg)
          SHIFT: begin
            lfsr_reg   <= lfsr_next;
            misr_reg   <= misr_next;
            sh_cnt_reg <= sh_last ? '0 : sh_cnt_reg + 1'b1;
          end
          CAPTURE: begin
            lfsr_reg <= lfsr_next;
            misr_reg <= misr_next;
            if (!pat_last) pat_cnt_reg <= pat_cnt_reg + 1'b1;
          end
          UNLOAD: begin
            misr_reg   <= misr_next;
            sh_cnt_reg <= sh_last ? '0 : sh_cnt_reg + 1'b1;
          end
          COMPARE: pass_fail_reg <= (misr_reg == GOLDEN);
          default: ;
        endcase
      end
    end
  end

  assign pass_fail = pass_fail_reg;
  assign signature = misr_reg;

endmodule
